// File: rtl/mesh_pkg.sv
`default_nettype none
// ============================================================================
// Package : mesh_pkg
// Brief   : Shared mesh packet field layout and destination matching.
// Revision: 1.0
// ============================================================================
package mesh_pkg;

    // Field positions are measured downward from the packet MSB.
    localparam int NXT_JUMP_MSB = 0;
    localparam int ROW_MSB      = 8;
    localparam int COL_MSB      = 12;

    localparam logic [7:0] BROADCAST = 8'hFF;

    function automatic logic dest_match(
        input logic [7:0] pkt,
        input logic [3:0] row,
        input logic [3:0] col
    );
        return (pkt == {row, col}) || (pkt == BROADCAST);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mesh_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mesh_rr_arbiter
// Brief   : Round-robin search: lowest pending request at or after ptr.
// Revision: 1.0
// ============================================================================
module mesh_rr_arbiter #(
    parameter int  N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          valid
);

    logic [IW:0] w_pos;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        w_pos = '0;
        // Walk offsets from farthest to nearest so the nearest match wins.
        for (int k = N - 1; k >= 0; k--) begin
            w_pos = {1'b0, ptr} + (IW + 1)'(k);
            if (w_pos >= (IW + 1)'(N)) begin
                w_pos = w_pos - (IW + 1)'(N);
            end
            if (en && req[w_pos[IW-1:0]]) begin
                valid = 1'b1;
                idx   = w_pos[IW-1:0];
            end
        end
        if (valid) begin
            gnt[idx] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mesh_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mesh_port_arbiter
// Brief   : N-to-1 round-robin ingress arbiter with destination filter and
//           first-word-fall-through output FIFO.
// Revision: 1.0
// ============================================================================
module mesh_port_arbiter
    import mesh_pkg::*;
#(
    parameter int PCKG_SZ    = 40,
    parameter int NUM_IN     = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int ID_ROW     = 0,
    parameter int ID_COL     = 0,
    parameter int FILTER_EN  = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_IN-1:0]         pndng_in,
    input  logic [NUM_IN*PCKG_SZ-1:0] data_in,
    output logic [NUM_IN-1:0]         pop_in,
    output logic                      pndng,
    output logic [PCKG_SZ-1:0]        data_out,
    input  logic                      pop,
    output logic                      full,
    output logic [15:0]               drop_cnt
);

    localparam int c_IW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_CW = $clog2(FIFO_DEPTH + 1);

    logic [PCKG_SZ-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]    r_wptr;
    logic [c_AW-1:0]    r_rptr;
    logic [c_CW-1:0]    r_count;
    logic               r_full;
    logic [c_IW-1:0]    r_rr_ptr;
    logic [15:0]        r_drop_cnt;

    logic [NUM_IN-1:0]  w_gnt;
    logic [c_IW-1:0]    w_idx;
    logic               w_gnt_vld;
    logic               w_arb_en;
    logic [PCKG_SZ-1:0] w_head;
    logic               w_accept;
    logic               w_push;
    logic               w_drop;
    logic               w_pop;
    logic [c_CW-1:0]    w_count_nxt;

    // Grants stay quiet while reset is held so upstream never loses a head.
    assign w_arb_en = !r_full && reset;

    mesh_rr_arbiter #(
        .N(NUM_IN)
    ) u_rr (
        .req  (pndng_in),
        .ptr  (r_rr_ptr),
        .en   (w_arb_en),
        .gnt  (w_gnt),
        .idx  (w_idx),
        .valid(w_gnt_vld)
    );

    assign w_head   = data_in[int'(w_idx)*PCKG_SZ +: PCKG_SZ];
    assign w_accept = (FILTER_EN == 0) ||
                      dest_match(w_head[PCKG_SZ-1-NXT_JUMP_MSB -: 8], 4'(ID_ROW), 4'(ID_COL));
    assign w_push   = w_gnt_vld && w_accept;
    assign w_drop   = w_gnt_vld && !w_accept;
    assign w_pop    = pop && (r_count != '0);

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + c_CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - c_CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_rr_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_AW'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_CW'(FIFO_DEPTH));
            if (w_gnt_vld) begin
                r_rr_ptr <= (w_idx == c_IW'(NUM_IN - 1)) ? '0 : w_idx + c_IW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wptr] <= w_head;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign pop_in   = w_gnt;
    assign pndng    = (r_count != '0);
    assign data_out = r_mem[r_rptr];
    assign full     = r_full;
    assign drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mesh_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mesh_port_arbiter
// Brief   : Randomized bench for mesh_port_arbiter against a queue-based model.
// Revision: 1.0
// ============================================================================
module tb_mesh_port_arbiter;

    localparam int N = 4;
    localparam int W = 40;
    localparam int D = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [N-1:0]   pndng_in;
    logic [N*W-1:0] data_in;
    logic [N-1:0]   pop_in;
    logic           pndng, pop, full;
    logic [W-1:0]   data_out;
    logic [15:0]    drop_cnt;

    logic           s_pndng_in, s_pop_in, s_pndng, s_pop, s_full;
    logic [W-1:0]   s_data_in, s_data_out;
    logic [15:0]    s_drop_cnt;

    mesh_port_arbiter #(
        .PCKG_SZ(W), .NUM_IN(N), .FIFO_DEPTH(D), .ID_ROW(0), .ID_COL(0), .FILTER_EN(1)
    ) dut (
        .clk(clk), .reset(reset), .pndng_in(pndng_in), .data_in(data_in), .pop_in(pop_in),
        .pndng(pndng), .data_out(data_out), .pop(pop), .full(full), .drop_cnt(drop_cnt)
    );

    mesh_port_arbiter #(
        .PCKG_SZ(W), .NUM_IN(1), .FIFO_DEPTH(2), .ID_ROW(0), .ID_COL(0), .FILTER_EN(1)
    ) dut1 (
        .clk(clk), .reset(reset), .pndng_in(s_pndng_in), .data_in(s_data_in), .pop_in(s_pop_in),
        .pndng(s_pndng), .data_out(s_data_out), .pop(s_pop), .full(s_full), .drop_cnt(s_drop_cnt)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model: upstream queues, output FIFO queue, fairness pointer.
    logic [W-1:0] chq [N][$];
    logic [W-1:0] outq[$];
    int           rr;
    int           drops;
    int           exp_g;
    logic [N-1:0] exp_pop_in;

    function automatic logic [W-1:0] make_pkt(input int kind);
        logic [7:0] nj;
        case (kind)
            0:       nj = 8'h00;
            1:       nj = 8'hFF;
            default: nj = 8'($urandom_range(1, 254));
        endcase
        return {nj, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 24'($urandom)};
    endfunction

    function automatic logic accepted(input logic [W-1:0] p);
        return (p[W-1 -: 8] == 8'h00) || (p[W-1 -: 8] == 8'hFF);
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            pndng_in[i]         = (chq[i].size() > 0);
            data_in[i*W +: W]   = (chq[i].size() > 0) ? chq[i][0] : '0;
        end
        exp_g = -1;
        if (outq.size() < D) begin
            for (int k = 0; k < N; k++) begin
                if (exp_g < 0 && chq[(rr + k) % N].size() > 0) exp_g = (rr + k) % N;
            end
        end
        exp_pop_in = '0;
        if (exp_g >= 0) exp_pop_in[exp_g] = 1'b1;
    endtask

    task automatic advance();
        logic [W-1:0] p;
        if (pop && outq.size() > 0) void'(outq.pop_front());
        if (exp_g >= 0) begin
            p = chq[exp_g].pop_front();
            if (accepted(p)) outq.push_back(p);
            else if (drops < 65535) drops++;
            rr = (exp_g + 1) % N;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        pop = 1'b0;
        s_pop = 1'b0;
        s_pndng_in = 1'b0;
        s_data_in = '0;
        for (int i = 0; i < N; i++) chq[i].delete();
        outq.delete();
        rr = 0;
        drops = 0;
        drive_inputs();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        reset = 1'b0;
        #1;
        n_total++; if (pop_in !== 4'b0000) $display("FAIL reset_pop_in got=%b exp=0000", pop_in); else n_pass++;
        n_total++; if (pndng !== 1'b0) $display("FAIL reset_pndng got=%b exp=0", pndng); else n_pass++;
        n_total++; if (full !== 1'b0) $display("FAIL reset_full got=%b exp=0", full); else n_pass++;
        n_total++; if (drop_cnt !== 16'h0) $display("FAIL reset_drop_cnt got=%h exp=0000", drop_cnt); else n_pass++;
        n_total++; if (data_out !== '0) $display("FAIL reset_data_out got=%h exp=0", data_out); else n_pass++;
        n_total++; if (s_pndng !== 1'b0 || s_full !== 1'b0) $display("FAIL reset_single got=%b%b exp=00", s_pndng, s_full); else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_interleave();
        logic [W-1:0] order[6];
        logic [N-1:0] pat;
        do_reset();
        for (int j = 0; j < 3; j++) begin
            order[2*j]   = make_pkt(0);
            order[2*j+1] = make_pkt(0);
            chq[0].push_back(order[2*j]);
            chq[2].push_back(order[2*j+1]);
        end
        pop = 1'b1;
        for (int c = 0; c < 8; c++) begin
            drive_inputs();
            #1;
            pat = (c >= 6) ? 4'b0000 : ((c % 2 == 0) ? 4'b0001 : 4'b0100);
            n_total++; if (pop_in !== pat) $display("FAIL interleave_pop_in cyc=%0d got=%b exp=%b", c, pop_in, pat); else n_pass++;
            if (c >= 1 && c <= 6) begin
                n_total++;
                if (pndng !== 1'b1 || data_out !== order[c-1])
                    $display("FAIL interleave_data cyc=%0d got=%b/%h exp=1/%h", c, pndng, data_out, order[c-1]);
                else n_pass++;
            end
            advance();
        end
        pop = 1'b0;
    endtask

    task automatic test_filter();
        logic [W-1:0] bc;
        do_reset();
        chq[1].push_back({8'h23, 8'h00, 24'h00ABCD});
        drive_inputs();
        #1;
        n_total++; if (pop_in !== 4'b0010) $display("FAIL filter_pop_in got=%b exp=0010", pop_in); else n_pass++;
        advance();
        drive_inputs();
        #1;
        n_total++; if (pndng !== 1'b0) $display("FAIL filter_pndng got=%b exp=0", pndng); else n_pass++;
        n_total++; if (drop_cnt !== 16'd1) $display("FAIL filter_drop_cnt got=%0d exp=1", drop_cnt); else n_pass++;
        bc = make_pkt(1);
        chq[1].push_back(bc);
        drive_inputs();
        #1;
        n_total++; if (pop_in !== 4'b0010) $display("FAIL bcast_pop_in got=%b exp=0010", pop_in); else n_pass++;
        advance();
        drive_inputs();
        #1;
        n_total++; if (pndng !== 1'b1 || data_out !== bc) $display("FAIL bcast_accept got=%b/%h exp=1/%h", pndng, data_out, bc); else n_pass++;
        n_total++; if (drop_cnt !== 16'd1) $display("FAIL bcast_drop_cnt got=%0d exp=1", drop_cnt); else n_pass++;
    endtask

    task automatic test_fill_full();
        int pulses = 0;
        do_reset();
        for (int i = 0; i < N; i++) for (int j = 0; j < 8; j++) chq[i].push_back(make_pkt(0));
        for (int c = 0; c < 20; c++) begin
            drive_inputs();
            #1;
            if (pop_in != '0) pulses++;
            n_total++; if (pop_in !== exp_pop_in) $display("FAIL fill_pop_in cyc=%0d got=%b exp=%b", c, pop_in, exp_pop_in); else n_pass++;
            n_total++; if (full !== (outq.size() == D)) $display("FAIL fill_full cyc=%0d got=%b exp=%b", c, full, outq.size() == D); else n_pass++;
            advance();
        end
        n_total++; if (pulses != 16) $display("FAIL fill_writes got=%0d exp=16", pulses); else n_pass++;
        pop = 1'b1;
        drive_inputs();
        #1;
        n_total++; if (pop_in !== 4'b0000 || full !== 1'b1) $display("FAIL full_pop_block got=%b/%b exp=0000/1", pop_in, full); else n_pass++;
        advance();
        pop = 1'b0;
        drive_inputs();
        #1;
        n_total++; if (full !== 1'b0) $display("FAIL full_release got=%b exp=0", full); else n_pass++;
        n_total++; if (pop_in !== exp_pop_in || pop_in == 4'b0000) $display("FAIL full_next_grant got=%b exp=%b", pop_in, exp_pop_in); else n_pass++;
        advance();
    endtask

    task automatic test_saturate();
        do_reset();
        force dut.r_drop_cnt = 16'hFFFE;
        #1;
        release dut.r_drop_cnt;
        drops = 65534;
        for (int j = 0; j < 3; j++) chq[3].push_back(make_pkt(2));
        for (int c = 0; c < 4; c++) begin
            drive_inputs();
            #1;
            n_total++; if (drop_cnt !== 16'(drops)) $display("FAIL sat_drop_cnt cyc=%0d got=%h exp=%h", c, drop_cnt, 16'(drops)); else n_pass++;
            advance();
        end
        #1;
        n_total++; if (drop_cnt !== 16'hFFFF) $display("FAIL sat_final got=%h exp=ffff", drop_cnt); else n_pass++;
    endtask

    task automatic test_reset_mid_burst();
        logic [W-1:0] first0;
        do_reset();
        for (int i = 0; i < N; i++) for (int j = 0; j < 8; j++) chq[i].push_back(make_pkt(0));
        for (int c = 0; c < 7; c++) begin
            drive_inputs();
            advance();
        end
        #1;
        n_total++; if (pndng !== 1'b1 || outq.size() != 7) $display("FAIL midrst_pre got=%b exp=1 (model count %0d)", pndng, outq.size()); else n_pass++;
        reset = 1'b0;
        drive_inputs();
        #1;
        n_total++; if (pndng !== 1'b0 || full !== 1'b0 || pop_in !== 4'b0000)
            $display("FAIL midrst_flush got=%b/%b/%b exp=0/0/0000", pndng, full, pop_in); else n_pass++;
        outq.delete();
        rr = 0;
        @(negedge clk);
        reset = 1'b1;
        first0 = chq[0][0];
        drive_inputs();
        #1;
        n_total++; if (pop_in !== 4'b0001) $display("FAIL midrst_first_grant got=%b exp=0001", pop_in); else n_pass++;
        advance();
        drive_inputs();
        #1;
        n_total++; if (pndng !== 1'b1 || data_out !== first0) $display("FAIL midrst_data got=%b/%h exp=1/%h", pndng, data_out, first0); else n_pass++;
    endtask

    task automatic test_random();
        int ch;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 99) < 70) begin
                ch = $urandom_range(0, N - 1);
                if (chq[ch].size() < 6) chq[ch].push_back(make_pkt($urandom_range(0, 2)));
            end
            pop = (c < 200) ? ($urandom_range(0, 99) < 30) : ($urandom_range(0, 99) < 85);
            drive_inputs();
            #1;
            n_total++; if (pop_in !== exp_pop_in) $display("FAIL rand_pop_in cyc=%0d got=%b exp=%b", c, pop_in, exp_pop_in); else n_pass++;
            n_total++; if (pndng !== (outq.size() > 0)) $display("FAIL rand_pndng cyc=%0d got=%b exp=%b", c, pndng, outq.size() > 0); else n_pass++;
            n_total++; if (full !== (outq.size() == D)) $display("FAIL rand_full cyc=%0d got=%b exp=%b", c, full, outq.size() == D); else n_pass++;
            n_total++; if (drop_cnt !== 16'(drops)) $display("FAIL rand_drop_cnt cyc=%0d got=%0d exp=%0d", c, drop_cnt, drops); else n_pass++;
            if (outq.size() > 0) begin
                n_total++; if (data_out !== outq[0]) $display("FAIL rand_data_out cyc=%0d got=%h exp=%h", c, data_out, outq[0]); else n_pass++;
            end
            advance();
        end
        pop = 1'b0;
    endtask

    task automatic test_single_channel();
        logic [W-1:0] spk[20];
        int idx = 0;
        do_reset();
        for (int j = 0; j < 20; j++) spk[j] = make_pkt(j % 2);
        s_pop = 1'b1;
        for (int c = 0; c < 23; c++) begin
            s_pndng_in = (idx < 20);
            s_data_in  = (idx < 20) ? spk[idx] : '0;
            #1;
            n_total++; if (s_pop_in !== (idx < 20)) $display("FAIL single_pop_in cyc=%0d got=%b exp=%b", c, s_pop_in, idx < 20); else n_pass++;
            n_total++; if (s_full !== 1'b0) $display("FAIL single_full cyc=%0d got=%b exp=0", c, s_full); else n_pass++;
            if (c >= 1 && c <= 20) begin
                n_total++; if (s_pndng !== 1'b1 || s_data_out !== spk[c-1])
                    $display("FAIL single_data cyc=%0d got=%b/%h exp=1/%h", c, s_pndng, s_data_out, spk[c-1]); else n_pass++;
            end else if (c > 20) begin
                n_total++; if (s_pndng !== 1'b0) $display("FAIL single_drain cyc=%0d got=%b exp=0", c, s_pndng); else n_pass++;
            end
            if (idx < 20) idx++;
            @(negedge clk);
        end
        s_pop = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        pop = 1'b0;
        pndng_in = '0;
        data_in = '0;
        s_pop = 1'b0;
        s_pndng_in = 1'b0;
        s_data_in = '0;
        test_reset();
        test_interleave();
        test_filter();
        test_fill_full();
        test_saturate();
        test_reset_mid_burst();
        test_random();
        test_single_channel();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
